iter_divider: RTL and testbench

Multi-cycle RV32M divide/remainder unit that sits beside the single-cycle ALU in the execute stage. The ALU handles MUL combinationally; this block performs DIV, DIVU, REM and REMU with a radix-2 restoring algorithm over 32 iterations. A start/busy/done handshake lets the control unit stall the datapath while it runs. Special cases, divide-by-zero and signed overflow, finish in one cycle with RISC-V-mandated results.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_step.sv | 21 ++
 rtl/iter_divider.sv | 143 ++++++++++++++
 tb/tb_iter_divider.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared RV32M divide opcodes and FSM states.
// Also imported by the control unit for stall decode.
package div_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  function automatic logic [XLEN-1:0] mag(
    input logic [XLEN-1:0] v,
    input logic            sgn
  );
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN:0]   pr,
  input  logic            nbit,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN:0]   pr_next,
  output logic            q
);

  logic [XLEN+1:0] sh;
  logic [XLEN:0]   diff;

  assign sh      = {pr, nbit};
  assign q       = (sh >= {2'b00, dvsr});
  assign diff    = sh[XLEN:0] - {1'b0, dvsr};
  assign pr_next = q ? diff : sh[XLEN:0];

endmodule

// File: rtl/iter_divider.sv
// RV32M DIV/DIVU/REM/REMU, 32-iteration restoring divider
// with start/busy/done handshake and one-cycle special cases.
module iter_divider
  import div_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] Result_o
);

  state_t state;
  state_t state_nxt;

  logic [4:0]      cnt;
  logic            op_rem;
  logic [XLEN:0]   pr;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvsr;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] res;

  logic            accept;
  logic            sgn;
  logic            div0;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] spec_res;

  logic [XLEN:0]   pr_nxt;
  logic            q_bit;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fin_res;
  logic            last;

  assign accept  = start_i & ~busy_o & funct3_i[2];
  assign sgn     = ~funct3_i[0];
  assign div0    = (rs2_i == '0);
  assign ovf     = sgn & (rs1_i == INT_MIN) & (rs2_i == '1);
  assign special = div0 | ovf;

  // Divide-by-zero wins over overflow.
  always_comb begin
    spec_res = '0;
    if (div0)
      spec_res = funct3_i[1] ? rs1_i : '1;
    else
      spec_res = funct3_i[1] ? '0 : INT_MIN;
  end

  div_step u_step (
    .pr      (pr),
    .nbit    (quo[XLEN-1]),
    .dvsr    (dvsr),
    .pr_next (pr_nxt),
    .q       (q_bit)
  );

  assign quo_nxt = {quo[XLEN-2:0], q_bit};
  assign q_fix   = neg_q ? -quo_nxt : quo_nxt;
  assign r_fix   = neg_r ? -pr_nxt[XLEN-1:0]
                         : pr_nxt[XLEN-1:0];
  assign fin_res = op_rem ? r_fix : q_fix;
  assign last    = (state == CALC) && (cnt == 5'd31);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nxt = special ? FIN : CALC;
      end
      CALC: begin
        if (cnt == 5'd31)
          state_nxt = FIN;
      end
      FIN: begin
        if (accept)
          state_nxt = special ? FIN : CALC;
        else
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    unique case (state)
      CALC:    busy_o = 1'b1;
      FIN:     done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= '0;
      op_rem <= 1'b0;
      pr     <= '0;
      quo    <= '0;
      dvsr   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      res    <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op_rem <= funct3_i[1];
      pr     <= '0;
      quo    <= mag(rs1_i, sgn);
      dvsr   <= mag(rs2_i, sgn);
      neg_q  <= sgn & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
      neg_r  <= sgn & rs1_i[XLEN-1];
      if (special)
        res <= spec_res;
    end else if (state == CALC) begin
      cnt <= cnt + 5'd1;
      pr  <= pr_nxt;
      quo <= quo_nxt;
      if (last)
        res <= fin_res;
    end
  end

  assign Result_o = res;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: results, latency,
// busy width, ignored starts, reset abort, back-to-back.
module tb_iter_divider;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  iter_divider dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .funct3_i (funct3),
    .start_i  (start),
    .busy_o   (busy),
    .done_o   (done),
    .Result_o (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic launch(input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] expv,
                        input bit push);
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    start  = 1'b1;
    if (push) exp_q.push_back(expv);
  endtask

  task automatic wait_done(input string tag,
                           input int exp_lat,
                           input int poke);
    int lat;
    int bz;
    lat = 0;
    bz  = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (poke != 0 && lat == poke) begin
        funct3 = F3_DIV;
        rs1    = 32'd55;
        rs2    = 32'd3;
        start  = 1'b1;
      end
      if (poke != 0 && lat == poke + 1) start = 1'b0;
      if (busy) bz++;
    end while (!done && lat < 100);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, bz, (exp_lat == 33) ? 32 : 0);
    if (exp_q.size() > 0)
      check({tag, "_res"}, result, exp_q.pop_front());
    else
      check({tag, "_noexp"}, 32'd1, 32'd0);
  endtask

  task automatic run(input string tag,
                     input logic [2:0] f3,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] expv,
                     input int exp_lat);
    @(negedge clk);
    launch(f3, a, b, expv, 1'b1);
    wait_done(tag, exp_lat, 0);
  endtask

  initial begin
    int seen;
    logic [31:0] held;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_res", result, 32'd0);
    rst = 1'b0;

    run("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2, 33);
    run("div_m100_7", F3_DIV, 32'hFFFF_FF9C, 32'd7,
        32'hFFFF_FFF2, 33);
    run("rem_m100_7", F3_REM, 32'hFFFF_FF9C, 32'd7,
        32'hFFFF_FFFE, 33);
    run("div_7_m2", F3_DIV, 32'd7, 32'hFFFF_FFFE,
        32'hFFFF_FFFD, 33);
    run("rem_7_m2", F3_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);

    run("div_5_0", F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("remu_5_0", F3_REMU, 32'd5, 32'd0, 32'd5, 1);
    run("divu_0_0", F3_DIVU, 32'd0, 32'd0, 32'hFFFF_FFFF, 1);

    run("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1);
    run("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 1);
    run("divu_ovf", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 33);

    // MUL-class funct3 must be ignored
    @(negedge clk);
    launch(3'b000, 32'd9, 32'd3, 32'd0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("mul_ign_busy", {31'b0, busy}, 32'd0);
    check("mul_ign_done", {31'b0, done}, 32'd0);

    @(negedge clk);
    launch(F3_DIVU, 32'd1000, 32'd10, 32'd100, 1'b1);
    wait_done("poke", 33, 10);
    held = result;
    @(negedge clk);
    check("hold_res", result, held);
    check("hold_done", {31'b0, done}, 32'd0);

    @(negedge clk);
    launch(F3_DIVU, 32'd100, 32'd7, 32'd0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_res", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_abort", seen, 0);
    run("divu_max_1", F3_DIVU, 32'hFFFF_FFFF, 32'd1,
        32'hFFFF_FFFF, 33);

    @(negedge clk);
    launch(F3_DIVU, 32'd1000, 32'd7, 32'd142, 1'b1);
    wait_done("b2b_first", 33, 0);
    launch(F3_REMU, 32'd17, 32'd5, 32'd2, 1'b1);
    wait_done("b2b_second", 33, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
